// File: rtl/udp_rx_unpacker_pkg.sv
// Shared definitions for the UDP receive unpacker: FSM encoding,
// header length and word-geometry helper.
package udp_rx_unpacker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    // UDP length field counts the 8-byte UDP header as well as the payload.
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    // Number of payload bytes packed into one application word.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/udp_rx_word_packer.sv
// Byte-to-word pack register. Bytes land MSB-first; the word (with the
// current byte already merged) and its keep mask are presented
// combinationally so the caller can register them in the commit cycle.
module udp_rx_word_packer
    import udp_rx_unpacker_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                byte_last,
    output logic                commit,
    output logic [DATA_W-1:0]   word_data,
    output logic [DATA_W/8-1:0] word_keep,
    output logic [15:0]         byte_cnt
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = $clog2(BPW);

    logic [DATA_W-1:0] pack_q, pack_d;
    logic [DATA_W-1:0] merged;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;

    // Per byte lane: merge the incoming byte into its slot and build the keep
    // mask as leading ones up to and including the current slot.
    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            assign merged[DATA_W-1-8*gi -: 8] =
                (byte_valid && (idx_q == IDX_W'(gi))) ? byte_data
                                                      : pack_q[DATA_W-1-8*gi -: 8];
            assign word_keep[BPW-1-gi] = (IDX_W'(gi) <= idx_q);
        end
    endgenerate

    assign commit    = byte_valid && (byte_last || (idx_q == IDX_W'(BPW - 1)));
    assign word_data = merged;
    assign byte_cnt  = cnt_q;

    // Next-state for pack register, slot index and frame byte counter.
    always_comb begin
        pack_d = pack_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        if (frame_start) begin
            pack_d = '0;
            idx_d  = '0;
            cnt_d  = '0;
        end else if (byte_valid) begin
            cnt_d = cnt_q + 16'd1;
            if (commit) begin
                // Clearing here is what zero-fills unused lanes of a partial word.
                pack_d = '0;
                idx_d  = '0;
            end else begin
                pack_d = merged;
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // Pack state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            pack_q <= pack_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/udp_rx_unpacker.sv
// UDP receive unpacker: filters frames on local IP/port, packs accepted
// payload bytes MSB-first into DATA_W-bit words, drains and counts the rest.
module udp_rx_unpacker
    import udp_rx_unpacker_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_udp_hdr_valid,
    output logic                rx_udp_hdr_ready,
    input  logic [31:0]         rx_udp_ip_source_ip,
    input  logic [31:0]         rx_udp_ip_dest_ip,
    input  logic [15:0]         rx_udp_source_port,
    input  logic [15:0]         rx_udp_dest_port,
    input  logic [15:0]         rx_udp_length,
    input  logic [7:0]          rx_udp_payload_axis_tdata,
    input  logic                rx_udp_payload_axis_tvalid,
    output logic                rx_udp_payload_axis_tready,
    input  logic                rx_udp_payload_axis_tlast,
    input  logic                rx_udp_payload_axis_tuser,
    input  logic [31:0]         local_ip,
    input  logic [15:0]         local_port,
    output logic [DATA_W-1:0]   dout_data,
    output logic [DATA_W/8-1:0] dout_keep,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                dout_err,
    output logic [31:0]         dout_src_ip,
    output logic [15:0]         dout_src_port,
    output logic [15:0]         rx_frame_cnt,
    output logic [15:0]         rx_drop_cnt
);

    localparam int BPW = bytes_per_word(DATA_W);

    rx_state_e state_q, state_d;
    logic      hdr_ready_q, hdr_ready_d;

    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] exp_len_q, exp_len_d;

    logic [DATA_W-1:0] dout_data_q, dout_data_d;
    logic [BPW-1:0]    dout_keep_q, dout_keep_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;
    logic              dout_err_q, dout_err_d;
    logic [31:0]       dout_src_ip_q, dout_src_ip_d;
    logic [15:0]       dout_src_port_q, dout_src_port_d;

    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic              hdr_fire;
    logic              hdr_match;
    logic              byte_fire;
    logic              recv_fire;
    logic              pk_commit;
    logic [DATA_W-1:0] pk_word;
    logic [BPW-1:0]    pk_keep;
    logic [15:0]       pk_byte_cnt;

    assign hdr_fire  = rx_udp_hdr_valid && hdr_ready_q;
    assign hdr_match = (rx_udp_ip_dest_ip == local_ip) && (rx_udp_dest_port == local_port);
    assign byte_fire = rx_udp_payload_axis_tvalid && rx_udp_payload_axis_tready;
    assign recv_fire = byte_fire && (state_q == ST_RECV);

    // Payload ready: held off in IDLE, gated by output-register space in RECV,
    // always open while draining a filtered frame.
    always_comb begin
        rx_udp_payload_axis_tready = 1'b0;
        case (state_q)
            ST_RECV: rx_udp_payload_axis_tready = !dout_valid_q || dout_ready;
            ST_DROP: rx_udp_payload_axis_tready = 1'b1;
            default: rx_udp_payload_axis_tready = 1'b0;
        endcase
    end

    udp_rx_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (hdr_fire),
        .byte_valid  (recv_fire),
        .byte_data   (rx_udp_payload_axis_tdata),
        .byte_last   (rx_udp_payload_axis_tlast),
        .commit      (pk_commit),
        .word_data   (pk_word),
        .word_keep   (pk_keep),
        .byte_cnt    (pk_byte_cnt)
    );

    // FSM next state, header latch, frame/drop counters.
    always_comb begin
        state_d     = state_q;
        src_ip_d    = src_ip_q;
        src_port_d  = src_port_q;
        exp_len_d   = exp_len_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    src_ip_d   = rx_udp_ip_source_ip;
                    src_port_d = rx_udp_source_port;
                    exp_len_d  = rx_udp_length - UDP_HDR_LEN;
                    state_d    = hdr_match ? ST_RECV : ST_DROP;
                end
            end
            ST_RECV: begin
                if (recv_fire && rx_udp_payload_axis_tlast) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (byte_fire && rx_udp_payload_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so it reads 0 in reset and rises one cycle after release.
        hdr_ready_d = (state_d == ST_IDLE);
    end

    // Output word register: drain on handshake, reload on commit. Commit only
    // happens when the register is empty or draining, so no word is lost.
    always_comb begin
        dout_data_d     = dout_data_q;
        dout_keep_d     = dout_keep_q;
        dout_valid_d    = dout_valid_q;
        dout_last_d     = dout_last_q;
        dout_err_d      = dout_err_q;
        dout_src_ip_d   = dout_src_ip_q;
        dout_src_port_d = dout_src_port_q;
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
        if (pk_commit) begin
            dout_data_d     = pk_word;
            dout_keep_d     = pk_keep;
            dout_valid_d    = 1'b1;
            dout_last_d     = rx_udp_payload_axis_tlast;
            dout_err_d      = rx_udp_payload_axis_tlast &&
                              (rx_udp_payload_axis_tuser ||
                               ((pk_byte_cnt + 16'd1) != exp_len_q));
            // Snapshot sender so a following header cannot disturb a held word.
            dout_src_ip_d   = src_ip_q;
            dout_src_port_d = src_port_q;
        end
    end

    // Control, header and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hdr_ready_q <= 1'b0;
            src_ip_q    <= '0;
            src_port_q  <= '0;
            exp_len_q   <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hdr_ready_q <= hdr_ready_d;
            src_ip_q    <= src_ip_d;
            src_port_q  <= src_port_d;
            exp_len_q   <= exp_len_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_data_q     <= '0;
            dout_keep_q     <= '0;
            dout_valid_q    <= 1'b0;
            dout_last_q     <= 1'b0;
            dout_err_q      <= 1'b0;
            dout_src_ip_q   <= '0;
            dout_src_port_q <= '0;
        end else begin
            dout_data_q     <= dout_data_d;
            dout_keep_q     <= dout_keep_d;
            dout_valid_q    <= dout_valid_d;
            dout_last_q     <= dout_last_d;
            dout_err_q      <= dout_err_d;
            dout_src_ip_q   <= dout_src_ip_d;
            dout_src_port_q <= dout_src_port_d;
        end
    end

    assign rx_udp_hdr_ready = hdr_ready_q;
    assign dout_data        = dout_data_q;
    assign dout_keep        = dout_keep_q;
    assign dout_valid       = dout_valid_q;
    assign dout_last        = dout_last_q;
    assign dout_err         = dout_err_q;
    assign dout_src_ip      = dout_src_ip_q;
    assign dout_src_port    = dout_src_port_q;
    assign rx_frame_cnt     = frame_cnt_q;
    assign rx_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_unpacker.sv
// Directed bench for udp_rx_unpacker with DATA_W=64 and hand-computed words.
module tb_udp_rx_unpacker;

    localparam int DATA_W = 64;
    localparam logic [31:0] LOC_IP   = 32'h0A00_0002;
    localparam logic [15:0] LOC_PORT = 16'd1234;
    localparam logic [31:0] SRC_IP   = 32'h0A00_0009;
    localparam logic [15:0] SRC_PORT = 16'd4000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hdr_valid;
    logic              hdr_ready;
    logic [31:0]       src_ip, dst_ip;
    logic [15:0]       src_port, dst_port, udp_len;
    logic [7:0]        tdata;
    logic              tvalid, tready, tlast, tuser;
    logic [DATA_W-1:0] dout_data;
    logic [7:0]        dout_keep;
    logic              dout_valid, dout_ready, dout_last, dout_err;
    logic [31:0]       dout_src_ip;
    logic [15:0]       dout_src_port;
    logic [15:0]       frame_cnt, drop_cnt;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        err;
        logic [31:0] sip;
        logic [15:0] sport;
    } word_t;

    word_t      words[$];
    logic [7:0] payload [0:31];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         stall_cnt = 0;
    int         bp_seen = 0;

    always #5 clk = ~clk;

    udp_rx_unpacker #(.DATA_W(DATA_W)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .rx_udp_hdr_valid           (hdr_valid),
        .rx_udp_hdr_ready           (hdr_ready),
        .rx_udp_ip_source_ip        (src_ip),
        .rx_udp_ip_dest_ip          (dst_ip),
        .rx_udp_source_port         (src_port),
        .rx_udp_dest_port           (dst_port),
        .rx_udp_length              (udp_len),
        .rx_udp_payload_axis_tdata  (tdata),
        .rx_udp_payload_axis_tvalid (tvalid),
        .rx_udp_payload_axis_tready (tready),
        .rx_udp_payload_axis_tlast  (tlast),
        .rx_udp_payload_axis_tuser  (tuser),
        .local_ip                   (LOC_IP),
        .local_port                 (LOC_PORT),
        .dout_data                  (dout_data),
        .dout_keep                  (dout_keep),
        .dout_valid                 (dout_valid),
        .dout_ready                 (dout_ready),
        .dout_last                  (dout_last),
        .dout_err                   (dout_err),
        .dout_src_ip                (dout_src_ip),
        .dout_src_port              (dout_src_port),
        .rx_frame_cnt               (frame_cnt),
        .rx_drop_cnt                (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every completed output handshake (inputs only change after posedge).
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            words.push_back('{dout_data, dout_keep, dout_last, dout_err, dout_src_ip, dout_src_port});
            $display("[TB] word data=%016h keep=%02h last=%0b err=%0b", dout_data, dout_keep, dout_last, dout_err);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [31:0] dip, input logic [15:0] dport, input logic [15:0] len);
        bit ok = 1'b0;
        hdr_valid = 1'b1; src_ip = SRC_IP; src_port = SRC_PORT;
        dst_ip = dip; dst_port = dport; udp_len = len;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk); ok = hdr_ready;
            @(posedge clk);
            if (ok) break;
        end
        #1 hdr_valid = 1'b0;
        chk("hdr_accept", ok, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
        bit ok = 1'b0;
        tvalid = 1'b1; tdata = d; tlast = last; tuser = user;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk); ok = tready;
            @(posedge clk);
            if (ok) break;
            stall_cnt++;
        end
        #1 tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        if (!ok) chk("byte_accept_timeout", ok, 1);
    endtask

    task automatic send_frame(input logic [15:0] dport, input logic [15:0] len, input int n, input logic bad);
        send_hdr(LOC_IP, dport, len);
        stall_cnt = 0;
        for (int i = 0; i < n; i++) send_byte(payload[i], i == n - 1, bad && (i == n - 1));
    endtask

    task automatic chk_word(input int idx, input logic [63:0] d, input logic [7:0] k, input logic l, input logic e);
        if (idx < words.size()) begin
            chk($sformatf("w%0d_data", idx), words[idx].data, d);
            chk($sformatf("w%0d_keep", idx), words[idx].keep, k);
            chk($sformatf("w%0d_last", idx), words[idx].last, l);
            chk($sformatf("w%0d_err", idx),  words[idx].err,  e);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hdr_valid = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        tdata = '0; src_ip = '0; dst_ip = '0; src_port = '0; dst_port = '0; udp_len = '0;
        dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) payload[i] = 8'(i);
        cycles(3);
        chk("rst_hdr_ready", hdr_ready, 0);
        chk("rst_tready", tready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rel_hdr_ready_low", hdr_ready, 0);
        cycles(1);
        chk("rel_hdr_ready_high", hdr_ready, 1);

        // 16-byte accepted frame.
        words.delete();
        send_frame(LOC_PORT, 16'd24, 16, 1'b0);
        cycles(4);
        chk("f1_nwords", words.size(), 2);
        chk_word(0, 64'h0001020304050607, 8'hFF, 1'b0, 1'b0);
        chk_word(1, 64'h08090A0B0C0D0E0F, 8'hFF, 1'b1, 1'b0);
        if (words.size() > 0) begin
            chk("f1_src_ip", words[0].sip, SRC_IP);
            chk("f1_src_port", words[0].sport, SRC_PORT);
        end
        chk("f1_frame_cnt", frame_cnt, 1);

        // Port mismatch: drained without stalls, nothing emitted.
        words.delete();
        send_frame(16'd5678, 16'd24, 16, 1'b0);
        cycles(4);
        chk("drop_stalls", stall_cnt, 0);
        chk("drop_nwords", words.size(), 0);
        chk("drop_cnt", drop_cnt, 1);
        chk("drop_frame_cnt", frame_cnt, 1);

        // 5-byte partial word.
        payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
        payload[3] = 8'hDD; payload[4] = 8'hEE;
        words.delete();
        send_frame(LOC_PORT, 16'd13, 5, 1'b0);
        cycles(4);
        chk("p5_nwords", words.size(), 1);
        chk_word(0, 64'hAABBCCDDEE000000, 8'hF8, 1'b1, 1'b0);
        chk("p5_frame_cnt", frame_cnt, 2);
        for (int i = 0; i < 32; i++) payload[i] = 8'(i);

        // tuser on the last byte.
        words.delete();
        send_frame(LOC_PORT, 16'd24, 16, 1'b1);
        cycles(4);
        chk("tuser_nwords", words.size(), 2);
        chk_word(0, 64'h0001020304050607, 8'hFF, 1'b0, 1'b0);
        chk_word(1, 64'h08090A0B0C0D0E0F, 8'hFF, 1'b1, 1'b1);

        // Length field disagrees with byte count.
        words.delete();
        send_frame(LOC_PORT, 16'd30, 16, 1'b0);
        cycles(4);
        chk("len_nwords", words.size(), 2);
        chk_word(1, 64'h08090A0B0C0D0E0F, 8'hFF, 1'b1, 1'b1);
        chk("len_frame_cnt", frame_cnt, 4);

        // Output backpressure for 10 cycles mid-frame.
        words.delete();
        fork
            send_frame(LOC_PORT, 16'd24, 16, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1 dout_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (dout_valid) begin
                        chk("bp_tready", tready, 0);
                        bp_seen++;
                    end
                end
                @(posedge clk);
                #1 dout_ready = 1'b1;
            end
        join
        cycles(4);
        chk("bp_seen", bp_seen > 0, 1);
        chk("bp_nwords", words.size(), 2);
        chk_word(0, 64'h0001020304050607, 8'hFF, 1'b0, 1'b0);
        chk_word(1, 64'h08090A0B0C0D0E0F, 8'hFF, 1'b1, 1'b0);
        chk("bp_frame_cnt", frame_cnt, 5);

        // Reset in the middle of a frame with a word held in the output register.
        words.delete();
        dout_ready = 1'b0;
        send_hdr(LOC_IP, LOC_PORT, 16'd24);
        for (int i = 0; i < 8; i++) send_byte(payload[i], 1'b0, 1'b0);
        chk("mr_pre_valid", dout_valid, 1);
        tvalid = 1'b1; tdata = payload[8];
        #2 rst_n = 1'b0;
        #1;
        chk("mr_dout_valid", dout_valid, 0);
        chk("mr_dout_data", dout_data, 0);
        chk("mr_dout_keep", dout_keep, 0);
        chk("mr_hdr_ready", hdr_ready, 0);
        chk("mr_tready", tready, 0);
        chk("mr_frame_cnt", frame_cnt, 0);
        dout_ready = 1'b1;
        cycles(2);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("mr_rel_tready", tready, 0);
        cycles(1);
        chk("mr_hdr_ready_up", hdr_ready, 1);
        @(negedge clk);
        chk("mr_idle_holdoff", tready, 0);
        @(posedge clk);
        #1 tvalid = 1'b0;
        payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
        payload[3] = 8'hDD; payload[4] = 8'hEE;
        words.delete();
        send_frame(LOC_PORT, 16'd13, 5, 1'b0);
        cycles(4);
        chk("mr_nwords", words.size(), 1);
        chk_word(0, 64'hAABBCCDDEE000000, 8'hF8, 1'b1, 1'b0);
        chk("mr_post_frame_cnt", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
